// File: rtl/hex_display_counter.sv
// hex_display_counter: DIGITS-digit up/down counter with prescaler, parallel
// load, runtime hex/BCD mode, terminal-count pulse and registered active-low
// 7-segment decode (bit order gfedcba, bit0 = a).
// Optional build macro HEX_DISPLAY_BLANK_EN: leading-zero blanking of HEX.
module hex_display_counter #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1
) (
    input  logic                  CLOCK,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  mode_bcd,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic [7*DIGITS-1:0]   HEX
);

    localparam int CW = 4 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]     r_presc;
    logic [CW-1:0]     r_count;
    logic              r_tc;
    logic              w_tick;
    logic [CW-1:0]     w_load_val;
    logic [CW-1:0]     w_bcd_next;
    logic              w_bcd_wrap;
    logic [CW-1:0]     w_hex_next;
    logic              w_hex_wrap;
    logic [DIGITS-1:0] w_blank;
    logic              w_carry;
    logic [3:0]        w_nib;

    assign w_tick = en && (r_presc == PRESC_LAST);
    assign count  = r_count;
    assign tc     = r_tc;

    // Active-low segment pattern for one hex nibble.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    // Load value, with non-decimal nibbles clamped to 9 in BCD mode.
    always_comb begin
        w_load_val = load_val;
        for (int i = 0; i < DIGITS; i++) begin
            if (mode_bcd && (load_val[4*i +: 4] > 4'd9)) begin
                w_load_val[4*i +: 4] = 4'd9;
            end
        end
    end

    // BCD ripple step; stray nibbles above 9 behave as 9 when the carry/borrow reaches them.
    always_comb begin
        w_bcd_next = r_count;
        w_carry    = 1'b1;
        w_nib      = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            w_nib = (r_count[4*i +: 4] > 4'd9) ? 4'd9 : r_count[4*i +: 4];
            if (w_carry) begin
                if (up_dn) begin
                    if (w_nib == 4'd9) begin
                        w_bcd_next[4*i +: 4] = 4'd0;
                    end else begin
                        w_bcd_next[4*i +: 4] = w_nib + 4'd1;
                        w_carry = 1'b0;
                    end
                end else begin
                    if (w_nib == 4'd0) begin
                        w_bcd_next[4*i +: 4] = 4'd9;
                    end else begin
                        w_bcd_next[4*i +: 4] = w_nib - 4'd1;
                        w_carry = 1'b0;
                    end
                end
            end
        end
        w_bcd_wrap = w_carry;
    end

    // Binary step and wrap detection for hex mode.
    always_comb begin
        w_hex_next = up_dn ? (r_count + CW'(1)) : (r_count - CW'(1));
        w_hex_wrap = up_dn ? (r_count == {CW{1'b1}}) : (r_count == '0);
    end

`ifdef HEX_DISPLAY_BLANK_EN
    logic w_zero_above;
    // A digit blanks when it and every digit above it are zero; digit 0 never blanks.
    always_comb begin
        w_blank      = '0;
        w_zero_above = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            w_zero_above = w_zero_above && (r_count[4*i +: 4] == 4'd0);
            w_blank[i]   = w_zero_above;
        end
    end
`else
    assign w_blank = '0;
`endif

    // Prescaler: advances only while enabled, restarts on tick or load.
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (load) begin
            r_presc <= '0;
        end else if (en) begin
            r_presc <= w_tick ? '0 : (r_presc + PW'(1));
        end
    end

    // Count register: load has priority over a tick.
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= w_load_val;
        end else if (w_tick) begin
            r_count <= mode_bcd ? w_bcd_next : w_hex_next;
        end
    end

    // Terminal-count pulse for the cycle after a wrapping tick.
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            r_tc <= 1'b0;
        end else begin
            r_tc <= !load && w_tick && (mode_bcd ? w_bcd_wrap : w_hex_wrap);
        end
    end

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [6:0] r_seg;
            // Registered segment decode (with optional blanking) for this digit.
            always_ff @(posedge CLOCK or posedge reset) begin
                if (reset) begin
                    r_seg <= 7'h40;
                end else begin
                    r_seg <= w_blank[gi] ? 7'h7F : seg7(r_count[4*gi +: 4]);
                end
            end
            assign HEX[7*gi +: 7] = r_seg;
        end
    endgenerate

endmodule

// File: tb/tb_hex_display_counter.sv
// Directed self-checking bench for hex_display_counter (DIGITS=4).
// Instance u_p1 uses PRESCALE=1, instance u_p3 uses PRESCALE=3; inputs are shared.
module tb_hex_display_counter;

    logic        CLOCK = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0, up_dn = 1'b1, mode_bcd = 1'b0, load = 1'b0;
    logic [15:0] load_val = 16'h0;
    logic [15:0] count1, count3;
    logic        tc1, tc3;
    logic [27:0] hex1, hex3;

    int checks = 0;
    int failures = 0;

    hex_display_counter #(.DIGITS(4), .PRESCALE(1)) u_p1 (
        .CLOCK(CLOCK), .reset(reset), .en(en), .up_dn(up_dn), .mode_bcd(mode_bcd),
        .load(load), .load_val(load_val), .count(count1), .tc(tc1), .HEX(hex1));

    hex_display_counter #(.DIGITS(4), .PRESCALE(3)) u_p3 (
        .CLOCK(CLOCK), .reset(reset), .en(en), .up_dn(up_dn), .mode_bcd(mode_bcd),
        .load(load), .load_val(load_val), .count(count3), .tc(tc3), .HEX(hex3));

    always #5 CLOCK = ~CLOCK;

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Expected HEX bus for a given count value.
    function automatic logic [27:0] exp_hex(input logic [15:0] c);
        logic [27:0] r;
        logic        above;
        logic [3:0]  n;
        r = '0;
        above = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            n = c[4*i +: 4];
            above = above && (n == 4'd0);
            r[7*i +: 7] = seg_tbl[n];
`ifdef HEX_DISPLAY_BLANK_EN
            if (above && i > 0) r[7*i +: 7] = 7'h7F;
`endif
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    typedef struct {
        logic        ld;
        logic [15:0] lv;
        logic        en;
        logic        up;
        logic        bcd;
        logic [15:0] c;
        logic        t;
    } vec_t;

    vec_t vecs [17];

    task automatic p3(input string name, input logic e, input logic ld,
                      input logic [15:0] lv, input logic [15:0] c);
        en = e; load = ld; load_val = lv;
        step();
        chk({name, "_count"}, {16'h0, count3}, {16'h0, c});
        chk({name, "_tc"}, {31'h0, tc3}, 32'h0);
        $display("p3 %s: en=%0b load=%0b count=%h", name, e, ld, count3);
    endtask

    initial begin
        logic [15:0] prev;
        //            ld  lv        en up bcd count     tc
        vecs[0]  = '{1'b1, 16'hFFFE, 1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0};
        vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0};
        vecs[5]  = '{1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h9999, 1'b1};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h9998, 1'b0};
        vecs[9]  = '{1'b1, 16'h12AF, 1'b0, 1'b0, 1'b1, 16'h1299, 1'b0};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1300, 1'b0};
        vecs[11] = '{1'b1, 16'h00AF, 1'b0, 1'b1, 1'b0, 16'h00AF, 1'b0};
        vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0100, 1'b0};
        vecs[13] = '{1'b1, 16'h9999, 1'b1, 1'b1, 1'b1, 16'h9999, 1'b0};
        vecs[14] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1};
        vecs[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b1};
        vecs[16] = '{1'b1, 16'h0042, 1'b1, 1'b1, 1'b0, 16'h0042, 1'b0};

        // Power-on reset held across clock edges.
        repeat (2) step();
        chk("rst_count", {16'h0, count1}, 32'h0);
        chk("rst_tc", {31'h0, tc1}, 32'h0);
        chk("rst_hex", {4'h0, hex1}, {4'h0, 7'h40, 7'h40, 7'h40, 7'h40});
        $display("reset: count=%h tc=%0b hex=%h", count1, tc1, hex1);
        reset = 1'b0;

        // Table-driven vectors on the PRESCALE=1 instance.
        prev = 16'h0000;
        for (int i = 0; i < 17; i++) begin
            load = vecs[i].ld; load_val = vecs[i].lv; en = vecs[i].en;
            up_dn = vecs[i].up; mode_bcd = vecs[i].bcd;
            step();
            chk($sformatf("v%0d_count", i), {16'h0, count1}, {16'h0, vecs[i].c});
            chk($sformatf("v%0d_tc", i), {31'h0, tc1}, {31'h0, vecs[i].t});
            chk($sformatf("v%0d_hex", i), {4'h0, hex1}, {4'h0, exp_hex(prev)});
            $display("vec %0d: count=%h tc=%0b hex=%h", i, count1, tc1, hex1);
            prev = vecs[i].c;
        end

        // HEX catches up with count one cycle later.
        load = 1'b0; en = 1'b0;
        step();
        chk("hex_0042", {4'h0, hex1}, {4'h0, exp_hex(16'h0042)});
        $display("hex 0042: hex=%h", hex1);

        // Asynchronous reset asserted between clock edges.
        #3 reset = 1'b1;
        #1;
        chk("arst_count", {16'h0, count1}, 32'h0);
        chk("arst_tc", {31'h0, tc1}, 32'h0);
        chk("arst_hex", {4'h0, hex1}, {4'h0, 7'h40, 7'h40, 7'h40, 7'h40});
        $display("async reset: count=%h tc=%0b hex=%h", count1, tc1, hex1);
        step();
        reset = 1'b0; up_dn = 1'b1; mode_bcd = 1'b0;

        // Prescale=3: one step every third enabled cycle.
        p3("pre_idle", 1'b0, 1'b0, 16'h0, 16'h0000);
        p3("pre_c1", 1'b1, 1'b0, 16'h0, 16'h0000);
        p3("pre_c2", 1'b1, 1'b0, 16'h0, 16'h0000);
        p3("pre_c3", 1'b1, 1'b0, 16'h0, 16'h0001);
        p3("pre_c4", 1'b1, 1'b0, 16'h0, 16'h0001);
        p3("pre_c5", 1'b1, 1'b0, 16'h0, 16'h0001);
        p3("pre_c6", 1'b1, 1'b0, 16'h0, 16'h0002);
        p3("pre_c7", 1'b1, 1'b0, 16'h0, 16'h0002);
        p3("pre_c8", 1'b1, 1'b0, 16'h0, 16'h0002);
        p3("pre_c9", 1'b1, 1'b0, 16'h0, 16'h0003);
        // Two enabled cycles, pause five, then one more completes the step.
        p3("pre_a1", 1'b1, 1'b0, 16'h0, 16'h0003);
        p3("pre_a2", 1'b1, 1'b0, 16'h0, 16'h0003);
        for (int i = 0; i < 5; i++) p3($sformatf("pre_hold%0d", i), 1'b0, 1'b0, 16'h0, 16'h0003);
        p3("pre_resume", 1'b1, 1'b0, 16'h0, 16'h0004);

        // Load on a tick cycle wins; next tick is a full prescale period later.
        p3("ldp_b1", 1'b1, 1'b0, 16'h0, 16'h0004);
        p3("ldp_b2", 1'b1, 1'b0, 16'h0, 16'h0004);
        p3("ldp_load", 1'b1, 1'b1, 16'h0042, 16'h0042);
        p3("ldp_n1", 1'b1, 1'b0, 16'h0, 16'h0042);
        p3("ldp_n2", 1'b1, 1'b0, 16'h0, 16'h0042);
        p3("ldp_n3", 1'b1, 1'b0, 16'h0, 16'h0043);
        step();
        chk("p3_hex", {4'h0, hex3}, {4'h0, exp_hex(16'h0043)});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
